pw_mem_arbiter: RTL and testbench
=================================

PW_MEM_ARBITER -- requirements
Module: pw_mem_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the password memory.
REQ-002 Parameter AW, default 16, memory address width.
REQ-003 Parameter DW, default 16, memory data width.
REQ-004 Parameter RD_LAT, default 2, memory read latency in clocks, legal range 1..7.
REQ-005 clk  input  1  single clock; all logic on posedge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 req_valid  input  NREQ  per-requester request.
REQ-008 req_wren  input  NREQ  per-requester write (1) / read (0).
REQ-009 req_addr  input  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW].
REQ-010 req_wdata  input  NREQ*DW  packed write data, same packing.
REQ-011 req_ready  output  NREQ  one-hot accept strobe.
REQ-012 rsp_valid  output  NREQ  one-hot completion strobe: read data or write ack.
REQ-013 rsp_data  output  DW  read data, valid while rsp_valid is nonzero.
REQ-014 mem_addr  output  AW  memory address.
REQ-015 mem_wren  output  1  memory write enable.
REQ-016 mem_wdata  output  DW  memory write data.
REQ-017 mem_rdata  input  DW  memory read data.
REQ-018 busy  output  1  high whenever the state is not IDLE.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction in flight at most.
REQ-020 IDLE: if any req_valid, grant index g by round-robin, searching ptr+1 upward with wrap; req_ready[g]=1 combinationally in that cycle (T); latch g, addr, wren, wdata; ptr<=g; go ISSUE. Otherwise stay IDLE.
REQ-021 req_ready SHALL be zero outside IDLE and zero in IDLE with no req_valid.
REQ-022 ISSUE (cycle T+1): mem_addr=latched addr; mem_wren=1 only for a write; write goes RESP, read goes WAIT with counter loaded to RD_LAT.
REQ-023 WAIT: decrement counter each cycle; in the cycle the counter is 1, capture mem_rdata into rsp_data and go RESP.
REQ-024 Memory contract: address sampled at the end of ISSUE; mem_rdata valid in cycle T+1+RD_LAT.
REQ-025 RESP: rsp_valid[g]=1 for exactly one cycle, then IDLE. Read response at T+2+RD_LAT (T+4 at default); write ack at T+2.
REQ-026 A write ack SHALL leave rsp_data unchanged; rsp_data holds the last read value between reads.
REQ-027 mem_wren SHALL be 0 in every state except ISSUE of a write; mem_addr/mem_wdata hold the last latched values when idle.
REQ-028 Requesters hold valid/payload stable until req_ready; deasserting req_valid before grant is a legal withdrawal with no side effect.
REQ-029 Simultaneous requests: all NREQ continuously valid SHALL produce grants 0,1,2,...,NREQ-1,0 in order; a lone requester is granted every transaction.
REQ-030 A new grant SHALL be possible in the IDLE cycle immediately following RESP.

Reset
REQ-031 rst=0 at a clock edge: state<=IDLE, ptr<=NREQ-1 (requester 0 has first priority), counter<=0, latched index/addr/wdata/wren<=0, rsp_data<=0.
REQ-032 After reset outputs SHALL be req_ready=0 (until a request arrives), rsp_valid=0, mem_wren=0, mem_addr=0, mem_wdata=0, busy=0.
REQ-033 Reset mid-transaction SHALL abort it with no rsp_valid for that transaction; mem_wren is 0 from the cycle after the reset edge.

Structure
REQ-034 Shared package pw_mem_pkg SHALL hold the state enum and the default NREQ/AW/DW/RD_LAT constants.
REQ-035 Round-robin selection SHALL be one sub-module, rr_arbiter: combinational request-vector plus pointer in, one-hot grant out; pointer register stays in pw_mem_arbiter.

Verification
REQ-036 Single read: req_valid=0001, addr=0x0005, memory[5]=0xBEEF -> req_ready=0001 at T, mem_addr=0x0005 at T+1, rsp_valid=0001 and rsp_data=0xBEEF at T+4.
REQ-037 Single write: requester 2 writes 0x1234 to 0x0010 -> mem_wren=1 for one cycle at T+1 with mem_addr=0x0010 and mem_wdata=0x1234, rsp_valid=0100 at T+2, rsp_data unchanged.
REQ-038 Fairness: req_valid=1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3, with no requester starved.
REQ-039 Withdrawal: requester 1 pulses req_valid while busy, then drops it before IDLE -> no grant, no response, and no memory access for 1.
REQ-040 Reset abort: rst=0 in WAIT of a read -> no rsp_valid, busy=0 next cycle; a following read by requester 0 is granted first and completes normally.

Source files
------------

// File: rtl/pw_mem_pkg.sv
// Shared types and default sizing for the password-memory arbiter.
package pw_mem_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int AW_DEF     = 16;
    localparam int DW_DEF     = 16;
    localparam int RD_LAT_DEF = 2;

    // Wide enough for the largest legal read latency (7).
    localparam int CNT_W      = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from ptr+1 with wrap,
// returns a one-hot grant (all zero when nothing requests).
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    int            pos;
    logic [IW-1:0] pos_idx;

    // First requester found after the pointer wins; later hits are ignored.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        gnt_o   = '0;
        pos     = 0;
        pos_idx = '0;
        for (int k = 1; k <= N; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = pos[IW-1:0];
            if (gnt_o == '0 && req_i[pos_idx]) begin
                gnt_o[pos_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pw_mem_arbiter.sv
// Shares one single-port password memory between NREQ requesters.
// One transaction in flight: IDLE grants, ISSUE drives the memory,
// WAIT covers read latency, RESP strobes the completion to the winner.
module pw_mem_arbiter
    import pw_mem_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_wren,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_wren,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             wren_q, wren_d;
    logic [DW-1:0]    rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]  gnt;
    logic [IW-1:0]    sel_idx;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic             sel_wren;

    rr_arbiter #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    // Turn the one-hot grant into an index and pick out the winner's payload.
    always_comb begin
        sel_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wren  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_idx   = IW'(i);
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
                sel_wren  = req_wren[i];
            end
        end
    end

    // Next-state logic: grant, issue, count out read latency, respond.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wren_d     = wren_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    idx_d   = sel_idx;
                    ptr_d   = sel_idx;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    wren_d  = sel_wren;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (wren_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Memory data is valid exactly in the last WAIT cycle.
                if (cnt_q == CNT_W'(1)) begin
                    rsp_data_d = mem_rdata;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled only on the clock edge, so rst stays out of
        // the sensitivity list; non-blocking assignments keep every register
        // updating from the same pre-edge values.
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(NREQ - 1);
            idx_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Handshake strobes: accept only while idle, complete only in RESP.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (state_q == IDLE) begin
            req_ready = gnt;
        end
        if (state_q == RESP) begin
            rsp_valid[idx_q] = 1'b1;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wren  = (state_q == ISSUE) && wren_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_pw_mem_arbiter.sv
// Bench for pw_mem_arbiter: transaction-level model (grant cycle + fixed
// latency schedule) checked every cycle, plus directed literal scenarios.
module tb_pw_mem_arbiter;

    localparam int NREQ   = 4;
    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int RD_LAT = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_wren;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [AW-1:0]      mem_addr;
    logic               mem_wren;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               busy;

    pw_mem_arbiter #(
        .NREQ   (NREQ),
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_wren  (req_wren),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .mem_addr  (mem_addr),
        .mem_wren  (mem_wren),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Requester-side stimulus state.
    logic [NREQ-1:0] rv;
    logic [NREQ-1:0] rw;
    logic [AW-1:0]   ra [NREQ];
    logic [DW-1:0]   rd [NREQ];
    logic            rst_v;

    // Reference model: memory contents plus one in-flight transaction.
    logic [DW-1:0]   mmem [256];
    bit              m_init;
    bit              m_busy;
    int              m_start;
    int              m_len;
    int              m_g;
    bit              m_wr;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    int              m_ptr;
    logic [AW-1:0]   m_mem_addr;
    logic [DW-1:0]   m_mem_wdata;
    logic [DW-1:0]   m_rsp_data;
    int              last_grant;

    int              cyc;
    int              n_tests;
    int              n_fail;

    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rsp;
    logic            exp_wren;
    logic            exp_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin rule: first valid requester after the last winner, wrapping.
    function automatic int model_pick();
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (rv[j]) return j;
        end
        return -1;
    endfunction

    // Expected outputs for this cycle, compare, then advance the model.
    task automatic model_cycle();
        int k;
        int g;
        k          = cyc - m_start;
        g          = -1;
        last_grant = -1;
        exp_ready  = '0;
        exp_rsp    = '0;
        exp_wren   = 1'b0;
        exp_busy   = m_busy;
        if (!m_busy) begin
            g = model_pick();
            if (g >= 0) begin
                exp_ready[g] = 1'b1;
                last_grant   = g;
            end
        end else begin
            if (k == 1 && m_wr) exp_wren = 1'b1;
            if (k == m_len) exp_rsp[m_g] = 1'b1;
        end

        if (m_init) begin
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
            check("mem_wren",  32'(mem_wren),  32'(exp_wren));
            check("busy",      32'(busy),      32'(exp_busy));
            check("mem_addr",  32'(mem_addr),  32'(m_mem_addr));
            check("mem_wdata", 32'(mem_wdata), 32'(m_mem_wdata));
            check("rsp_data",  32'(rsp_data),  32'(m_rsp_data));
        end

        if (!m_busy) begin
            if (g >= 0) begin
                m_busy      = 1'b1;
                m_start     = cyc;
                m_g         = g;
                m_wr        = rw[g];
                m_addr      = ra[g];
                m_wdata     = rd[g];
                m_len       = rw[g] ? 2 : 2 + RD_LAT;
                m_ptr       = g;
                m_mem_addr  = ra[g];
                m_mem_wdata = rd[g];
            end
        end else begin
            if (k == 1 && m_wr) mmem[m_addr[7:0]] = m_wdata;
            if (!m_wr && k == 1 + RD_LAT) m_rsp_data = mmem[m_addr[7:0]];
            if (k == m_len) m_busy = 1'b0;
        end

        if (!rst_v) begin
            m_busy      = 1'b0;
            m_ptr       = NREQ - 1;
            m_mem_addr  = '0;
            m_mem_wdata = '0;
            m_rsp_data  = '0;
            m_init      = 1'b1;
        end
    endtask

    // One clock: drive inputs after the edge, check on the falling edge.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        rst       = rst_v;
        req_valid = rv;
        req_wren  = rw;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]  = ra[i];
            req_wdata[i*DW +: DW] = rd[i];
        end
        // Memory returns data only in its contractual cycle; junk otherwise.
        if (m_busy && !m_wr && (cyc - m_start) == 1 + RD_LAT)
            mem_rdata = mmem[m_addr[7:0]];
        else
            mem_rdata = DW'($urandom());
        @(negedge clk);
        model_cycle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_grant;
        int cnt_rsp1;
        int cnt_rdy1;
        int cnt_wren;
        int gi;

        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        m_init    = 1'b0;
        m_busy    = 1'b0;
        m_start   = 0;
        m_len     = 0;
        m_g       = 0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        m_ptr     = NREQ - 1;
        m_mem_addr  = '0;
        m_mem_wdata = '0;
        m_rsp_data  = '0;
        rv        = '0;
        rw        = '0;
        rst_v     = 1'b0;
        rst       = 1'b0;
        req_valid = '0;
        req_wren  = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_rdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        for (int i = 0; i < 256; i++) mmem[i] = DW'($urandom());
        mmem[5] = 16'hBEEF;

        // Reset and idle outputs.
        step();
        step();
        rst_v = 1'b1;
        step();
        check("rst_busy",      32'(busy),      32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_mem_wren",  32'(mem_wren),  32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h0);

        // Single read by requester 0 of address 5.
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'h0005;
        step();
        check("rd_ready_T", 32'(req_ready), 32'h1);
        rv[0] = 1'b0;
        step();
        check("rd_mem_addr_T1", 32'(mem_addr), 32'h0005);
        step();
        step();
        step();
        check("rd_rsp_valid_T4", 32'(rsp_valid), 32'h1);
        check("rd_rsp_data_T4",  32'(rsp_data),  32'hBEEF);

        // Single write by requester 2, granted in the IDLE cycle right after RESP.
        rv[2] = 1'b1; rw[2] = 1'b1; ra[2] = 16'h0010; rd[2] = 16'h1234;
        step();
        check("wr_ready_T", 32'(req_ready), 32'h4);
        rv[2] = 1'b0;
        step();
        check("wr_mem_wren_T1",  32'(mem_wren),  32'h1);
        check("wr_mem_addr_T1",  32'(mem_addr),  32'h0010);
        check("wr_mem_wdata_T1", 32'(mem_wdata), 32'h1234);
        step();
        check("wr_rsp_valid_T2", 32'(rsp_valid), 32'h4);
        check("wr_rsp_data_T2",  32'(rsp_data),  32'hBEEF);
        step();
        check("wr_mem_wren_T3", 32'(mem_wren), 32'h0);

        // Withdrawal: requester 1 pulses a write while busy and drops it.
        cnt_rsp1 = 0; cnt_rdy1 = 0; cnt_wren = 0;
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'h0020;
        rw[1] = 1'b1; ra[1] = 16'h0030; rd[1] = 16'h5A5A;
        for (int c = 0; c < 9; c++) begin
            rv[1] = (c == 1 || c == 2);
            step();
            if (c == 0) rv[0] = 1'b0;
            if (c == 4) check("wd_rsp_valid_T4", 32'(rsp_valid), 32'h1);
            if (rsp_valid[1]) cnt_rsp1++;
            if (req_ready[1]) cnt_rdy1++;
            if (mem_wren) cnt_wren++;
        end
        check("wd_no_rsp1",   32'(cnt_rsp1), 32'h0);
        check("wd_no_grant1", 32'(cnt_rdy1), 32'h0);
        check("wd_no_write",  32'(cnt_wren), 32'h0);

        // Fairness from a fresh reset: all four continuously valid.
        rst_v = 1'b0;
        step();
        rst_v = 1'b1;
        rw = '0;
        for (int i = 0; i < NREQ; i++) ra[i] = AW'(i);
        rv = '1;
        n_grant = 0;
        for (int c = 0; c < 200 && n_grant < 8; c++) begin
            step();
            if (req_ready != '0) begin
                gi = -1;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
                check("fair_grant", 32'(gi), 32'(n_grant % NREQ));
                n_grant++;
            end
        end
        check("fair_count", 32'(n_grant), 32'd8);
        rv = '0;
        for (int c = 0; c < 6; c++) step();

        // Reset abort during WAIT of a read, then a normal read.
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 16'h0040;
        step();
        rv[0] = 1'b0;
        step();
        rst_v = 1'b0;
        step();
        check("ab_busy_wait", 32'(busy), 32'h1);
        rst_v = 1'b1;
        step();
        check("ab_busy_after",  32'(busy),      32'h0);
        check("ab_rsp_after",   32'(rsp_valid), 32'h0);
        check("ab_wren_after",  32'(mem_wren),  32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("ab_no_rsp", 32'(rsp_valid), 32'h0);
        end
        rv = '1; rw = '0;
        ra[0] = 16'h0005;
        step();
        check("ab_ready_first", 32'(req_ready), 32'h1);
        rv = '0;
        step();
        step();
        step();
        step();
        check("ab_rsp_valid", 32'(rsp_valid), 32'h1);
        check("ab_rsp_data",  32'(rsp_data),  32'hBEEF);

        // Randomized traffic with withdrawals and occasional resets.
        for (int c = 0; c < 1500; c++) begin
            rst_v = ($urandom_range(0, 299) != 0);
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (rv[i] && last_grant == i) begin
                    rv[i] = 1'b0;
                end else if (rv[i]) begin
                    if ($urandom_range(0, 15) == 0) rv[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    rv[i] = 1'b1;
                    rw[i] = 1'($urandom_range(0, 1));
                    ra[i] = AW'($urandom());
                    rd[i] = DW'($urandom());
                end
            end
        end
        rst_v = 1'b1;
        rv    = '0;
        for (int c = 0; c < 10; c++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
